// File: rtl/npc.sv
// npc: two-cycle FETCH/EXEC RV32E core with a unified 16 MiB word-addressed memory.
// Retires one instruction every second cycle with no flow control; EBREAK or an illegal instruction parks it in HALT.
module npc_mem_ext (
  input  logic        clock,
  input  logic [21:0] idx_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdat_i,
  output logic [31:0] rdat_o
);
  logic [31:0] Memory [0:4194303];

  assign rdat_o = Memory[idx_i];

  always_ff @(posedge clock) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) Memory[idx_i][8*b +: 8] <= wdat_i[8*b +: 8];
      end
    end
  end
endmodule

module npc_mem_wrap (
  input  logic        clock,
  input  logic [21:0] idx_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdat_i,
  output logic [31:0] rdat_o
);
  npc_mem_ext mem_ext (.clock(clock), .idx_i(idx_i), .we_i(we_i), .be_i(be_i), .wdat_i(wdat_i), .rdat_o(rdat_o));
endmodule

module npc_mem (
  input  logic        clock,
  input  logic [21:0] idx_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdat_i,
  output logic [31:0] rdat_o
);
  npc_mem_wrap Mem (.clock(clock), .idx_i(idx_i), .we_i(we_i), .be_i(be_i), .wdat_i(wdat_i), .rdat_o(rdat_o));
endmodule

module npc (
  input  logic clock,
  input  logic reset,
  output logic io_sync,
  output logic io_simEnd
);
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [31:0] ECALL    = 32'h0000_0073;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011,
                         OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_e;
  state_e state_q, state_d;

  logic [31:0] pc_q, pc_d, ir_q, ir_d;
  logic [31:0] rf_q [16];

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, alu_b, alu_res, ld_val, st_dat, rd_val, pc_next;
  logic [23:0] dat_addr;
  logic [21:0] mem_idx;
  logic [31:0] mem_rdat;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;
  logic [3:0]  st_be;
  logic        legal, is_ebreak, is_store, use_rs1, use_rs2, use_rd, br_taken;
  logic        halt_instr, exec_commit, mem_we;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u  = {ir_q[31:12], 12'b0};
  assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  // rf_q[0] is never written, so it reads as zero without a mux
  assign rs1_val  = rf_q[rs1[3:0]];
  assign rs2_val  = rf_q[rs2[3:0]];
  assign dat_addr = rs1_val[23:0] + ((opcode == OP_STORE) ? imm_s[23:0] : imm_i[23:0]);

  always_comb begin
    alu_b = (opcode == OP_OP) ? rs2_val : imm_i;
    case (f3)
      3'd0:    alu_res = ((opcode == OP_OP) && f7[5]) ? rs1_val - alu_b : rs1_val + alu_b;
      3'd1:    alu_res = rs1_val << alu_b[4:0];
      3'd2:    alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      3'd3:    alu_res = {31'b0, rs1_val < alu_b};
      3'd4:    alu_res = rs1_val ^ alu_b;
      3'd5:    alu_res = f7[5] ? 32'($signed(rs1_val) >>> alu_b[4:0]) : rs1_val >> alu_b[4:0];
      3'd6:    alu_res = rs1_val | alu_b;
      default: alu_res = rs1_val & alu_b;
    endcase
  end

  always_comb begin
    case (f3)
      3'd0:    br_taken = rs1_val == rs2_val;
      3'd1:    br_taken = rs1_val != rs2_val;
      3'd4:    br_taken = $signed(rs1_val) < $signed(rs2_val);
      3'd5:    br_taken = $signed(rs1_val) >= $signed(rs2_val);
      3'd6:    br_taken = rs1_val < rs2_val;
      3'd7:    br_taken = rs1_val >= rs2_val;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    case (dat_addr[1:0])
      2'd0:    ld_byte = mem_rdat[7:0];
      2'd1:    ld_byte = mem_rdat[15:8];
      2'd2:    ld_byte = mem_rdat[23:16];
      default: ld_byte = mem_rdat[31:24];
    endcase
    ld_half = dat_addr[1] ? mem_rdat[31:16] : mem_rdat[15:0];
    case (f3)
      3'd0:    ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_val = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_val = {24'b0, ld_byte};
      3'd5:    ld_val = {16'b0, ld_half};
      default: ld_val = mem_rdat;
    endcase
    case (f3[1:0])
      2'd0:    begin st_be = 4'b0001 << dat_addr[1:0];        st_dat = {4{rs2_val[7:0]}};  end
      2'd1:    begin st_be = dat_addr[1] ? 4'b1100 : 4'b0011; st_dat = {2{rs2_val[15:0]}}; end
      default: begin st_be = 4'b1111;                         st_dat = rs2_val;            end
    endcase
  end

  always_comb begin
    legal = 1'b1; is_ebreak = 1'b0; is_store = 1'b0;
    use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0;
    rd_val = alu_res; pc_next = pc_q + 32'd4;
    case (opcode)
      OP_LUI:    begin use_rd = 1'b1; rd_val = imm_u; end
      OP_AUIPC:  begin use_rd = 1'b1; rd_val = pc_q + imm_u; end
      OP_JAL:    begin use_rd = 1'b1; rd_val = pc_q + 32'd4; pc_next = pc_q + imm_j; end
      OP_JALR:   begin
        use_rd = 1'b1; use_rs1 = 1'b1; legal = (f3 == 3'd0);
        rd_val = pc_q + 32'd4; pc_next = (rs1_val + imm_i) & ~32'd1;
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; legal = (f3[2:1] != 2'b01);
        if (br_taken) pc_next = pc_q + imm_b;
      end
      OP_LOAD:   begin
        use_rd = 1'b1; use_rs1 = 1'b1; rd_val = ld_val;
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      end
      OP_STORE:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; is_store = 1'b1; legal = (f3 < 3'd3); end
      OP_IMM:    begin
        use_rd = 1'b1; use_rs1 = 1'b1;
        if (f3 == 3'd1)      legal = (f7 == 7'h00);
        else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
      end
      OP_OP:     begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
      end
      OP_FENCE:  ;
      OP_SYSTEM: begin
        if (ir_q == EBREAK)     is_ebreak = 1'b1;
        else if (ir_q != ECALL) legal = 1'b0;
      end
      default:   legal = 1'b0;
    endcase
    if ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd[4])) legal = 1'b0;
  end

  assign halt_instr = is_ebreak || !legal;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = S_EXEC;
      S_EXEC:  state_d = halt_instr ? S_HALT : S_FETCH;
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    io_sync     = (state_q == S_EXEC);
    io_simEnd   = ((state_q == S_EXEC) && halt_instr) || (state_q == S_HALT);
    exec_commit = (state_q == S_EXEC) && !halt_instr;
    mem_we      = exec_commit && is_store;
    mem_idx     = (state_q == S_FETCH) ? pc_q[23:2] : dat_addr[23:2];
  end

  npc_mem mem (.clock(clock), .idx_i(mem_idx), .we_i(mem_we), .be_i(st_be), .wdat_i(st_dat), .rdat_o(mem_rdat));

  always_comb begin
    ir_d = (state_q == S_FETCH) ? mem_rdat : ir_q;
    pc_d = exec_commit ? pc_next : pc_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      ir_q <= '0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      if (exec_commit && use_rd && (rd[3:0] != 4'd0)) rf_q[rd[3:0]] <= rd_val;
    end
  end
endmodule

// File: tb/tb_npc.sv
// Bench for npc: directed programs loaded by backdoor; a monitor pops expected retirements
// (pc, cycle, halt flag) and final register values whenever io_sync is seen.
module tb_npc;
  localparam int OPI = 7'b0010011, OPR = 7'b0110011, LD = 7'b0000011, ST = 7'b0100011;
  localparam int LUI = 7'b0110111, AUIPC = 7'b0010111, JALR = 7'b1100111;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  typedef struct { logic [31:0] pc; logic fin; int cyc; } ret_t;
  typedef struct { int idx; logic [31:0] val; } reg_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic io_sync, io_simEnd;

  ret_t ret_q[$];
  reg_t reg_q[$];
  logic [31:0] prog[$];
  int n_chk = 0, n_fail = 0, exp_k = 0, cyc = 0;
  bit running = 1'b0, halted = 1'b0;

  npc dut (.clock(clock), .reset(reset), .io_sync(io_sync), .io_simEnd(io_simEnd));

  always #5 clock = ~clock;

  function automatic logic [31:0] e_i(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] e_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] e_s(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] e_b(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] e_u(int imm, int rd, int op);
    return {imm[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] e_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_ret(input int off, input bit fin);
    exp_k++;
    ret_q.push_back('{pc: 32'h8000_0000 + off, fin: fin, cyc: 2 * exp_k});
  endtask

  task automatic exp_reg(input int idx, input logic [31:0] val);
    reg_q.push_back('{idx: idx, val: val});
  endtask

  // Monitor: counts cycles since reset release and checks each retirement
  initial begin
    ret_t e;
    reg_t r;
    forever begin
      @(negedge clock);
      if (!running) begin
        cyc = 0;
        halted = 1'b0;
      end else begin
        cyc++;
        if (io_sync) begin
          if (ret_q.size() == 0) check("unexpected_retire", 32'(io_sync), 32'd0);
          else begin
            e = ret_q.pop_front();
            check("retire_pc", dut.pc_q, e.pc);
            check("retire_cycle", cyc, e.cyc);
            check("retire_simend", 32'(io_simEnd), 32'(e.fin));
            if (e.fin) begin
              while (reg_q.size() > 0) begin
                r = reg_q.pop_front();
                check($sformatf("reg_x%0d", r.idx), dut.rf_q[r.idx], r.val);
              end
              halted = 1'b1;
            end
          end
        end else if (halted) check("halt_hold_simend", 32'(io_simEnd), 32'd1);
        else check("simend_low", 32'(io_simEnd), 32'd0);
      end
    end
  end

  task automatic run_prog();
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    check("rst_async_sync", 32'(io_sync), 32'd0);
    check("rst_async_simend", 32'(io_simEnd), 32'd0);
    check("rst_async_pc", dut.pc_q, 32'h8000_0000);
    running = 1'b0;
    for (int i = 0; i < prog.size(); i++) dut.mem.Mem.mem_ext.Memory[i] = prog[i];
    repeat (10) @(negedge clock);
    check("rst_hold_sync", 32'(io_sync), 32'd0);
    check("rst_hold_simend", 32'(io_simEnd), 32'd0);
    check("rst_hold_pc", dut.pc_q, 32'h8000_0000);
    @(posedge clock); #1;
    reset = 1'b1;
    running = 1'b1;
    for (int i = 0; i < 3000 && !halted; i++) @(negedge clock);
    if (!halted) check("halt_timeout", 32'd0, 32'd1);
    repeat (6) @(negedge clock);
    check("queue_drained", ret_q.size(), 32'd0);
    ret_q.delete();
    reg_q.delete();
    @(posedge clock); #1;
    running = 1'b0;
  endtask

  initial begin
    // ALU
    prog = '{e_i(-1, 0, 0, 1, OPI), e_i(28, 1, 5, 2, OPI), e_i(12'h404, 1, 5, 3, OPI),
             e_r(0, 2, 2, 0, 4), EBRK};
    exp_k = 0;
    for (int k = 0; k < 5; k++) exp_ret(4 * k, k == 4);
    exp_reg(1, 32'hFFFF_FFFF); exp_reg(2, 32'h0000_000F); exp_reg(3, 32'hFFFF_FFFF); exp_reg(4, 32'h1E);
    run_prog();

    // Memory: byte/half/word loads and stores, misaligned halves
    prog = '{e_u(20'h80001, 5, LUI), e_i(12'hAB, 0, 0, 1, OPI), e_s(1, 1, 5, 0),
             e_i(0, 5, 2, 6, LD), e_i(1, 5, 0, 7, LD), e_i(1, 5, 4, 8, LD),
             e_s(2, 1, 5, 1), e_i(0, 5, 2, 9, LD), e_i(1, 5, 1, 10, LD), EBRK};
    dut.mem.Mem.mem_ext.Memory[1024] = 32'h0;
    exp_k = 0;
    for (int k = 0; k < 10; k++) exp_ret(4 * k, k == 9);
    exp_reg(5, 32'h8000_1000); exp_reg(6, 32'h0000_AB00); exp_reg(7, 32'hFFFF_FFAB);
    exp_reg(8, 32'h0000_00AB); exp_reg(9, 32'h00AB_AB00); exp_reg(10, 32'hFFFF_AB00);
    run_prog();
    check("mem_word_1000", dut.mem.Mem.mem_ext.Memory[1024], 32'h00AB_AB00);

    // Control flow: jal, taken blt, not-taken bltu, auipc+jalr with LSB cleared
    prog = '{e_j(8, 1), e_i(1, 0, 0, 2, OPI), e_i(-1, 0, 0, 3, OPI), e_i(1, 0, 0, 4, OPI),
             e_b(8, 4, 3, 4), e_i(2, 0, 0, 2, OPI), e_b(8, 4, 3, 6), e_i(7, 0, 0, 5, OPI),
             e_u(0, 7, AUIPC), e_i(13, 7, 0, 6, JALR), e_i(3, 0, 0, 2, OPI), EBRK};
    exp_k = 0;
    exp_ret(0, 0); exp_ret(8, 0); exp_ret(12, 0); exp_ret(16, 0); exp_ret(24, 0);
    exp_ret(28, 0); exp_ret(32, 0); exp_ret(36, 0); exp_ret(44, 1);
    exp_reg(1, 32'h8000_0004); exp_reg(2, 32'h0); exp_reg(3, 32'hFFFF_FFFF); exp_reg(4, 32'h1);
    exp_reg(5, 32'h7); exp_reg(6, 32'h8000_0028); exp_reg(7, 32'h8000_0020);
    run_prog();

    // x0 stays zero; rd=x16 is illegal and halts without writeback
    prog = '{e_i(5, 0, 0, 0, OPI), e_i(9, 0, 0, 1, OPI), e_r(0, 0, 0, 0, 16), e_i(3, 0, 0, 1, OPI), EBRK};
    exp_k = 0;
    exp_ret(0, 0); exp_ret(4, 0); exp_ret(8, 1);
    exp_reg(0, 32'h0); exp_reg(1, 32'h9);
    run_prog();

    // Smoke: sum 10..1 in a loop, store, reload, invert
    prog = '{e_i(0, 0, 0, 1, OPI), e_i(10, 0, 0, 2, OPI), e_r(0, 2, 1, 0, 1), e_i(-1, 2, 0, 2, OPI),
             e_b(-8, 0, 2, 1), e_u(20'h80002, 3, LUI), e_s(0, 1, 3, 2), e_i(0, 3, 2, 4, LD),
             e_i(-1, 4, 4, 5, OPI), EBRK};
    exp_k = 0;
    exp_ret(0, 0); exp_ret(4, 0);
    for (int k = 0; k < 10; k++) begin
      exp_ret(8, 0); exp_ret(12, 0); exp_ret(16, 0);
    end
    exp_ret(20, 0); exp_ret(24, 0); exp_ret(28, 0); exp_ret(32, 0); exp_ret(36, 1);
    exp_reg(1, 32'd55); exp_reg(2, 32'd0); exp_reg(4, 32'd55); exp_reg(5, 32'hFFFF_FFC8);
    run_prog();
    check("mem_word_2000", dut.mem.Mem.mem_ext.Memory[2048], 32'd55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
